// File: rtl/apple1_pkg.sv
// apple1_pkg: shared Apple-1 types, default controller timing and memory map
// Holds the debug-state enum, the default CPU clock-enable / power-on-reset
// timing, and the address-decode constants used by the Apple-1 top level.
package apple1_pkg;
  typedef enum logic {ST_RUN, ST_HALTED} dbg_state_e;
  localparam int DEF_CLK_DIV = 25;
  localparam int DEF_CE_WIDTH = 12;
  localparam int DEF_POR_CYCLES = 63;
  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_TOP = 16'h0FFF;
  localparam logic [15:0] PIA_BASE = 16'hD010;
  localparam logic [15:0] PIA_TOP = 16'hD013;
  localparam logic [15:0] ROM_BASE = 16'hFF00;
endpackage

// File: rtl/apple1_sysctl_if.sv
// apple1_sysctl_if: control/status bundle of the Apple-1 system controller
// Requests into the controller: soft_rst, halt, step.
// Status out of the controller: cpu_clken, cpu_reset, tick, halted, cycle_count.
// slave = controller side, master = the logic that drives the requests.
interface apple1_sysctl_if #(
  parameter int CNT_W = 32
);
  logic             soft_rst;
  logic             halt;
  logic             step;
  logic             cpu_clken;
  logic             cpu_reset;
  logic             tick;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  modport slave (
    input  soft_rst, halt, step,
    output cpu_clken, cpu_reset, tick, halted, cycle_count
  );
  modport master (
    output soft_rst, halt, step,
    input  cpu_clken, cpu_reset, tick, halted, cycle_count
  );
endinterface

// File: rtl/apple1_sysctl_ce_window_gen.sv
// ce_window_gen: master-clock divider plus CPU clock-enable window generator
// Ports: clk25/rst_n (async active-low) clock and reset; gate qualifies the
// window at each tick; tick is high while the divider sits at 0; clken is the
// registered enable, high for CE_WIDTH clocks after each gated tick.
module ce_window_gen #(
  parameter int CLK_DIV = 25,
  parameter int CE_WIDTH = 12
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic gate,
  output logic tick,
  output logic clken
);
  logic [15:0] div_q, div_d, wid_q, wid_d;
  logic        clken_q, clken_d;
  always_comb begin
    tick = div_q == '0;
    div_d = (div_q == 16'(CLK_DIV - 1)) ? '0 : div_q + 16'd1;
    wid_d = (tick && gate) ? 16'(CE_WIDTH) : (wid_q != '0) ? wid_q - 16'd1 : '0;
    // registering the next width value puts clken high in exactly the
    // CE_WIDTH clocks that follow the issuing tick
    clken_d = wid_d != '0;
  end
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      wid_q   <= '0;
      clken_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      wid_q   <= wid_d;
      clken_q <= clken_d;
    end
  end
  assign clken = clken_q;
endmodule

// File: rtl/apple1_sysctl.sv
// apple1_sysctl: Apple-1 CPU clock-enable, reset sequencer and debug control
// Ports: clk25 master clock; rst_n async active-low reset; bus (slave) carries
// soft_rst/halt/step requests in and cpu_clken/cpu_reset/tick/halted/
// cycle_count out. Define SYSCTL_STEP_EN to build the halt/single-step FSM;
// without it halt/step are ignored and halted is tied low.
module apple1_sysctl
  import apple1_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CE_WIDTH = DEF_CE_WIDTH,
  parameter int POR_CYCLES = DEF_POR_CYCLES,
  parameter int CNT_W = 32
) (
  input  logic           clk25,
  input  logic           rst_n,
  apple1_sysctl_if.slave bus
);
  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
    $error("apple1_sysctl: CLK_DIV %0d outside 2..65535", CLK_DIV);
  end
  if (CE_WIDTH < 1 || CE_WIDTH > CLK_DIV - 1) begin : g_bad_width
    $error("apple1_sysctl: CE_WIDTH %0d outside 1..CLK_DIV-1", CE_WIDTH);
  end
  if (POR_CYCLES < 1 || POR_CYCLES > 65535) begin : g_bad_por
    $error("apple1_sysctl: POR_CYCLES %0d outside 1..65535", POR_CYCLES);
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("apple1_sysctl: CNT_W must be at least 1");
  end
  logic             tick, gate, win, clken;
  logic             cpu_reset_q, cpu_reset_d;
  logic [15:0]      por_q, por_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ce_window_gen #(
    .CLK_DIV (CLK_DIV),
    .CE_WIDTH(CE_WIDTH)
  ) u_ce (
    .clk25(clk25),
    .rst_n(rst_n),
    .gate (gate),
    .tick (tick),
    .clken(clken)
  );
`ifdef SYSCTL_STEP_EN
  dbg_state_e state_q, state_d;
  logic       step_pend_q, step_pend_d, halted_q, halted_d;
  // step_pend is only ever set in HALTED, so it can qualify the gate directly;
  // a pending reset overrides halt so the power-up sequence always completes
  always_comb begin
    gate = cpu_reset_q || !bus.halt || step_pend_q;
    state_d = bus.soft_rst ? ST_RUN : !tick ? state_q : (bus.halt && !cpu_reset_q) ? ST_HALTED : ST_RUN;
    step_pend_d = !bus.soft_rst && !(tick && gate) && (step_pend_q || (bus.step && state_q == ST_HALTED));
    halted_d = state_d == ST_HALTED;
  end
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      step_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      halted_q    <= halted_d;
    end
  end
  assign bus.halted = halted_q;
`else
  logic unused_dbg;
  assign gate = 1'b1;
  assign unused_dbg = bus.halt ^ bus.step;
  assign bus.halted = 1'b0;
`endif
  always_comb begin
    win = tick && gate;
    por_d = bus.soft_rst ? '0 : (win && cpu_reset_q) ? por_q + 16'd1 : por_q;
    // reset drops on the edge of the tick that issues window POR_CYCLES
    cpu_reset_d = bus.soft_rst || (cpu_reset_q && !(win && por_d == 16'(POR_CYCLES)));
    cnt_d = bus.soft_rst ? '0 : (win && !cpu_reset_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      cpu_reset_q <= 1'b1;
      por_q       <= '0;
      cnt_q       <= '0;
    end else begin
      cpu_reset_q <= cpu_reset_d;
      por_q       <= por_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.cpu_clken   = clken;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.tick        = tick;
  assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_apple1_sysctl.sv
// tb_apple1_sysctl: directed self-checking bench for apple1_sysctl
module tb_apple1_sysctl;
`ifdef SYSCTL_STEP_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif
  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  int   k, hi_a, hi_c, tk_a, x;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk25 = ~clk25;
  apple1_sysctl_if #(.CNT_W(32)) a_if ();
  apple1_sysctl_if #(.CNT_W(4))  b_if ();
  apple1_sysctl_if #(.CNT_W(32)) c_if ();
  apple1_sysctl u_a (.clk25(clk25), .rst_n(rst_n), .bus(a_if));
  apple1_sysctl #(.CLK_DIV(4), .CE_WIDTH(1), .POR_CYCLES(2), .CNT_W(4)) u_b (
    .clk25(clk25), .rst_n(rst_n), .bus(b_if));
  apple1_sysctl u_c (.clk25(clk25), .rst_n(rst_n), .bus(c_if));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step_clk();
    @(negedge clk25);
    k++;
    hi_a += int'(a_if.cpu_clken);
    hi_c += int'(c_if.cpu_clken);
    tk_a += int'(a_if.tick);
  endtask
  task automatic adv_to(input int n);
    while (k < n) step_clk();
  endtask
  initial begin
    a_if.soft_rst = 1'b0; a_if.halt = 1'b1; a_if.step = 1'b1;
    b_if.soft_rst = 1'b0; b_if.halt = 1'b0; b_if.step = 1'b0;
    c_if.soft_rst = 1'b0; c_if.halt = 1'b0; c_if.step = 1'b0;
    k = 0; hi_a = 0; hi_c = 0; tk_a = 0;
    repeat (3) @(negedge clk25);
    check("rst_clken", 32'(a_if.cpu_clken), 0);
    check("rst_cpu_reset", 32'(a_if.cpu_reset), 1);
    check("rst_tick", 32'(a_if.tick), 1);
    check("rst_halted", 32'(a_if.halted), 0);
    check("rst_count", a_if.cycle_count, 0);
    check("rst_b_cpu_reset", 32'(b_if.cpu_reset), 1);
    @(negedge clk25);
    rst_n = 1'b1;
    tk_a = int'(a_if.tick);
    check("a_tick_k0", 32'(a_if.tick), 1);
    adv_to(1);
    check("a_clken_k1", 32'(a_if.cpu_clken), 1);
    check("a_tick_k1", 32'(a_if.tick), 0);
    check("b_clken_k1", 32'(b_if.cpu_clken), 1);
    adv_to(2);
    check("b_clken_k2", 32'(b_if.cpu_clken), 0);
    adv_to(4);
    check("b_tick_k4", 32'(b_if.tick), 1);
    check("b_reset_k4", 32'(b_if.cpu_reset), 1);
    adv_to(5);
    check("b_reset_k5", 32'(b_if.cpu_reset), 0);
    check("b_clken_k5", 32'(b_if.cpu_clken), 1);
    adv_to(12);
    check("a_clken_k12", 32'(a_if.cpu_clken), 1);
    adv_to(13);
    check("a_clken_k13", 32'(a_if.cpu_clken), 0);
    adv_to(25);
    check("a_hi_per_period", 32'(hi_a), 12);
    check("a_tick_k25", 32'(a_if.tick), 1);
    adv_to(26);
    check("a_clken_k26", 32'(a_if.cpu_clken), 1);
    adv_to(46);
    check("b_count_10", 32'(b_if.cycle_count), 10);
    adv_to(66);
    check("b_count_15", 32'(b_if.cycle_count), 15);
    adv_to(70);
    check("b_count_wrap", 32'(b_if.cycle_count), 0);
    adv_to(1550);
    check("a_reset_k1550", 32'(a_if.cpu_reset), 1);
    adv_to(1551);
    check("a_reset_k1551", 32'(a_if.cpu_reset), 0);
    check("a_ticks_at_fall", 32'(tk_a), 63);
    check("a_count_at_fall", a_if.cycle_count, 0);
    check("a_halted_in_reset", 32'(a_if.halted), 0);
    check("c_reset_k1551", 32'(c_if.cpu_reset), 0);
    check("c_count_at_fall", c_if.cycle_count, 0);
    adv_to(1575);
    check("a_halted_k1575", 32'(a_if.halted), 0);
    hi_c = 0;
    adv_to(1576);
    check("c_count_k1576", c_if.cycle_count, 1);
    check("a_count_k1576", a_if.cycle_count, STEP ? 0 : 1);
    check("a_halted_k1576", 32'(a_if.halted), STEP ? 1 : 0);
    adv_to(1580);
    c_if.halt = 1'b1;
    adv_to(1600);
    check("c_window_completes", 32'(hi_c), 12);
    hi_c = 0;
    adv_to(1601);
    check("c_clken_k1601", 32'(c_if.cpu_clken), STEP ? 0 : 1);
    check("c_halted_k1601", 32'(c_if.halted), STEP ? 1 : 0);
    check("a_clken_k1601", 32'(a_if.cpu_clken), 1);
    check("a_count_k1601", a_if.cycle_count, STEP ? 1 : 2);
    for (int i = 0; i < 3; i++) begin
      adv_to(1605 + 3 * i);
      c_if.step = 1'b1;
      adv_to(1606 + 3 * i);
      c_if.step = 1'b0;
    end
    adv_to(1625);
    check("c_tick_k1625", 32'(c_if.tick), 1);
    adv_to(1626);
    check("c_clken_k1626", 32'(c_if.cpu_clken), 1);
    check("c_count_k1626", c_if.cycle_count, STEP ? 2 : 3);
    adv_to(1650);
    check("c_hi_after_steps", 32'(hi_c), STEP ? 12 : 24);
    adv_to(1651);
    check("c_clken_k1651", 32'(c_if.cpu_clken), STEP ? 0 : 1);
    check("c_count_k1651", c_if.cycle_count, STEP ? 2 : 4);
    adv_to(1655);
    c_if.halt = 1'b0;
    while (c_if.cycle_count != 100 && k < 6000) step_clk();
    check("c_count_100", c_if.cycle_count, 100);
    x = k;
    c_if.halt = 1'b1;
    adv_to(x + 24);
    check("c_tick_before_srst", 32'(c_if.tick), 1);
    adv_to(x + 25);
    check("c_halted_before_srst", 32'(c_if.halted), STEP ? 1 : 0);
    check("c_count_before_srst", c_if.cycle_count, STEP ? 100 : 101);
    adv_to(x + 29);
    c_if.soft_rst = 1'b1;
    adv_to(x + 30);
    c_if.soft_rst = 1'b0;
    check("srst_cpu_reset", 32'(c_if.cpu_reset), 1);
    check("srst_count", c_if.cycle_count, 0);
    check("srst_halted", 32'(c_if.halted), 0);
    adv_to(x + 29 + 1570);
    check("srst_reset_held", 32'(c_if.cpu_reset), 1);
    adv_to(x + 29 + 1571);
    check("srst_reset_fall", 32'(c_if.cpu_reset), 0);
    check("srst_count_at_fall", c_if.cycle_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apple1_sysctl.md
# apple1_sysctl

Parametrised system controller for the Apple-1 top level. It generates the CPU clock-enable window from the master clock and sequences the power-up and soft resets. It also provides halt/single-step debug control and a retired-CPU-cycle counter. It replaces the fixed 25-clock divider with its 12-clock enable window and the fixed 6-bit power-up counter, and drives the CPU `enable`/`reset` pins and the UART enable qualifier.

## Interface
Parameters:
- `CLK_DIV`, 25: master clocks per CPU cycle; legal range 2..65535.
- `CE_WIDTH`, 12: clocks per cycle during which `cpu_clken` is high; 1 ≤ `CE_WIDTH` ≤ `CLK_DIV`-1; elaboration error otherwise.
- `POR_CYCLES`, 63: CPU cycles (windows) that `cpu_reset` is held after reset or a soft reset; 1..65535.
- `CNT_W`, 32: width of `cycle_count`.

Ports:
- `clk25` in 1: master clock.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `soft_rst` in 1: synchronous soft-reset request, level; restarts the reset sequence.
- `halt` in 1: request to stop issuing CPU windows (debug).
- `step` in 1: single-clock pulse; issues one window while halted.
- `cpu_clken` out 1: CPU clock enable.
- `cpu_reset` out 1: active-high CPU reset.
- `tick` out 1: one-clock strobe, high when the divider is at 0.
- `halted` out 1: controller is in HALTED.
- `cycle_count` out `CNT_W`: CPU windows issued while `cpu_reset` is low.

## Operation
- Divider `div_cnt` counts 0..`CLK_DIV`-1 and wraps. `tick` = (`div_cnt`==0), decoded combinationally from the register.
- **Window issue.**
  - At a tick, the controller decides whether to issue a window. An issued window loads the width counter with `CE_WIDTH`.
  - `cpu_clken` is registered and is high while the width counter is nonzero.
- **Reset sequencer.**
  - `por_cnt` has 16 bits. It increments on each tick that issues a window while `cpu_reset`=1.
  - When `por_cnt` reaches `POR_CYCLES` at a tick, `cpu_reset` is cleared. The change is registered and takes effect in the following clock.
  - `soft_rst`=1 clears `por_cnt` and `cycle_count` and sets `cpu_reset` on the next edge. This holds for as long as `soft_rst` stays high.
  - The divider and any in-flight window are not disturbed.
- **Debug FSM.** States: RUN, HALTED.
  - RUN: every tick issues a window. If `halt`=1 at a tick and `cpu_reset`=0, the FSM goes to HALTED and that tick issues no window.
  - HALTED: a `step` pulse sets `step_pend`, which saturates, so multiple pulses within one period count as one.
    - At a tick with `halt`=1 and `step_pend`=1: issue one window, clear `step_pend`, stay in HALTED.
    - At a tick with `halt`=0: go to RUN, issue a window, and clear `step_pend`.
  - `cpu_reset`=1 forces RUN behaviour, so windows always run and the reset can complete. `halt` is ignored in this case.
  - A `soft_rst` while in HALTED forces RUN and clears `step_pend`.
- `halted` = (state==HALTED), registered.
- **Cycle counter.** `cycle_count` increments by 1 at each tick that issues a window with `cpu_reset`=0. It wraps modulo 2^`CNT_W`.
- A window in flight always completes its `CE_WIDTH` clocks. `halt` never truncates it.

## Timing
- Reset values: `div_cnt`=0, width counter 0, `cpu_clken`=0, `cpu_reset`=1, `por_cnt`=0, state RUN, `halted`=0, `step_pend`=0, `cycle_count`=0. `tick`=1 while in reset.
- If tick occurs in clock N and issues a window, `cpu_clken`=1 in clocks N+1..N+`CE_WIDTH`. The period is exactly `CLK_DIV` clocks.
- The first tick is the first edge after `rst_n` rises. `cpu_reset` falls one clock after the tick that issues window `POR_CYCLES`. Window `POR_CYCLES`+1 is the first window with reset low.
- `halt`/`step` are sampled on edges and have no combinational path to outputs. The halt decision lands on the next tick boundary, with a worst-case latency of `CLK_DIV` clocks.

## Configuration
- `SYSCTL_STEP_EN` defined: the debug FSM, `step_pend`, and `halted` are as described above.
- `SYSCTL_STEP_EN` undefined: `halt` and `step` are ignored, every tick issues a window, `halted` is tied to 0, and no FSM registers are inferred.

## Structure
- The shared package `apple1_pkg` holds:
  - the debug-state enum (RUN, HALTED);
  - the default divider, width, and POR constants;
  - the memory-map constants used by the top-level decode.
- One sub-module, `ce_window_gen`: the divider plus width counter, with a `gate` input and `tick`/`clken` outputs. The reset sequencer, FSM, and counter stay in `apple1_sysctl`.

## Test plan
- Default parameters, release `rst_n` → `cpu_clken` high 12 clocks of every 25; `cpu_reset` falls exactly 1 clock after the 63rd tick; `cycle_count`=0 at that point.
- `CLK_DIV`=4, `CE_WIDTH`=1, `POR_CYCLES`=2 → `cpu_clken` 1-of-4; reset low after the 2nd window; `cycle_count`=10 after 10 further windows.
- Assert `halt` mid-window after reset completes → the current window finishes its 12 clocks, then no windows follow and `halted`=1. Three `step` pulses in one period → exactly one window, and `cycle_count` increments by 1.
- `halt` and `step` both held while `cpu_reset`=1 → windows continue every 25 clocks, and `halted` only rises after reset completes.
- `soft_rst` pulsed while HALTED with `cycle_count`=100 → next edge `cpu_reset`=1, `cycle_count`=0, state RUN; `cpu_reset` low again after 63 ticks.
- `cycle_count` preset near wrap with `CNT_W`=4 → the count rolls over from 15 to 0. Without `SYSCTL_STEP_EN`, `halt`=1 has no effect on the window pattern.
